// File: rtl/issue_scoreboard_pkg.sv
// Shared constants for the issue scoreboard: instruction field positions,
// controller state encoding and the default in-flight write limit.
package issue_scoreboard_pkg;

  localparam int unsigned DST_MSB  = 24;
  localparam int unsigned DST_LSB  = 20;
  localparam int unsigned SRC1_MSB = 19;
  localparam int unsigned SRC1_LSB = 15;
  localparam int unsigned SRC2_MSB = 14;
  localparam int unsigned SRC2_LSB = 10;

  localparam int unsigned NUM_REGS         = 32;
  localparam int unsigned MAX_INFLIGHT_DEF = 4;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } sb_state_e;

endpackage

// File: rtl/issue_scoreboard_bits.sv
// 32-entry pending-write bit vector with one set port, one clear port and
// three combinational lookup ports; a set wins over a clear of the same bit.
module issue_scoreboard_bits
  import issue_scoreboard_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                set_en_i,
  input  reg_idx_t            set_idx_i,
  input  logic                clr_en_i,
  input  reg_idx_t            clr_idx_i,
  input  reg_idx_t            rd_a_idx_i,
  input  reg_idx_t            rd_b_idx_i,
  input  reg_idx_t            rd_c_idx_i,
  output logic                rd_a_busy_o,
  output logic                rd_b_busy_o,
  output logic                rd_c_busy_o,
  output logic                clr_hit_o,
  output logic [NUM_REGS-1:0] busy_vec_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en_i) set_mask = NUM_REGS'(1) << set_idx_i;
    if (clr_en_i) clr_mask = NUM_REGS'(1) << clr_idx_i;
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign rd_a_busy_o = busy_q[rd_a_idx_i];
  assign rd_b_busy_o = busy_q[rd_b_idx_i];
  assign rd_c_busy_o = busy_q[rd_c_idx_i];
  assign clr_hit_o   = clr_en_i & busy_q[clr_idx_i];
  assign busy_vec_o  = busy_q;

endmodule

// File: rtl/issue_scoreboard.sv
// Register-hazard scoreboard gating the decode stage, with drain sequencing
// and a saturating stall-cycle counter.
//
//   state    | meaning
//   ST_RUN   | normal issue; hazards alone decide dec_enable
//   ST_DRAIN | issue blocked, waiting for all pending writes to retire
//   ST_DONE  | drain complete, drain_done high for this one cycle
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                instr_valid_i,
  input  logic [31:0]         instruction_i,
  input  logic                uses_src1_i,
  input  logic                uses_src2_i,
  input  logic                writes_dst_i,
  input  logic                write_reg_i,
  input  reg_idx_t            write_reg_dst_i,
  input  logic                drain_req_i,
  output logic                dec_enable_o,
  output logic                stall_o,
  output logic                drain_done_o,
  output logic [NUM_REGS-1:0] busy_vec_o,
  output logic [3:0]          inflight_o,
  output logic [15:0]         stall_cnt_o
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_INFLIGHT);

  sb_state_e   state_q;
  logic        drain_done_q;
  logic [3:0]  inflight_q, inflight_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  reg_idx_t dst_idx, src1_idx, src2_idx;
  logic     dst_busy, src1_busy, src2_busy;
  logic     hazard, set_en, clr_eff;
  logic     unused_instr_bits;

  assign dst_idx  = instruction_i[DST_MSB:DST_LSB];
  assign src1_idx = instruction_i[SRC1_MSB:SRC1_LSB];
  assign src2_idx = instruction_i[SRC2_MSB:SRC2_LSB];
  assign unused_instr_bits = ^{instruction_i[31:DST_MSB+1], instruction_i[SRC2_LSB-1:0]};

  issue_scoreboard_bits u_bits (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .set_en_i    (set_en),
    .set_idx_i   (dst_idx),
    .clr_en_i    (write_reg_i),
    .clr_idx_i   (write_reg_dst_i),
    .rd_a_idx_i  (src1_idx),
    .rd_b_idx_i  (src2_idx),
    .rd_c_idx_i  (dst_idx),
    .rd_a_busy_o (src1_busy),
    .rd_b_busy_o (src2_busy),
    .rd_c_busy_o (dst_busy),
    .clr_hit_o   (clr_eff),
    .busy_vec_o  (busy_vec_o)
  );

  // Lookups see the pre-edge vector, so a same-cycle writeback cannot unblock a reader.
  assign hazard = (uses_src1_i & src1_busy) | (uses_src2_i & src2_busy) |
                  (writes_dst_i & dst_busy) | (writes_dst_i & (inflight_q == MAX_CNT));

  assign dec_enable_o = instr_valid_i & (state_q == ST_RUN) & ~hazard & ~rst_i;
  assign stall_o      = instr_valid_i & ~dec_enable_o;
  assign set_en       = dec_enable_o & writes_dst_i;

  always_comb begin
    inflight_d = inflight_q;
    if (set_en && !clr_eff && inflight_q != MAX_CNT) inflight_d = inflight_q + 4'd1;
    else if (clr_eff && !set_en && inflight_q != 4'd0) inflight_d = inflight_q - 4'd1;

    stall_cnt_d = stall_cnt_q;
    if (stall_o && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      drain_done_q <= 1'b0;
      inflight_q   <= '0;
      stall_cnt_q  <= '0;
    end else begin
      drain_done_q <= 1'b0;
      inflight_q   <= inflight_d;
      stall_cnt_q  <= stall_cnt_d;
      case (state_q)
        ST_RUN:   if (drain_req_i) state_q <= ST_DRAIN;
        ST_DRAIN: if (inflight_q == 4'd0) begin
                    state_q      <= ST_DONE;
                    drain_done_q <= 1'b1;
                  end
        ST_DONE:  state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  assign drain_done_o = drain_done_q;
  assign inflight_o   = inflight_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: a set-of-pending-registers model is
// compared every cycle, and literal expectations pin key scenario points.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instruction;
  logic        uses_src1, uses_src2, writes_dst;
  logic        write_reg;
  logic [4:0]  write_reg_dst;
  logic        drain_req;
  logic        dec_enable, stall, drain_done;
  logic [31:0] busy_vec;
  logic [3:0]  inflight;
  logic [15:0] stall_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // model: which registers await a write, drain phase (0 run,1 drain,2 done), stall count
  bit pend[32];
  int phase;
  int m_stalls;

  always #5 clk = ~clk;

  issue_scoreboard #(.MAX_INFLIGHT(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .instr_valid_i   (instr_valid),
    .instruction_i   (instruction),
    .uses_src1_i     (uses_src1),
    .uses_src2_i     (uses_src2),
    .writes_dst_i    (writes_dst),
    .write_reg_i     (write_reg),
    .write_reg_dst_i (write_reg_dst),
    .drain_req_i     (drain_req),
    .dec_enable_o    (dec_enable),
    .stall_o         (stall),
    .drain_done_o    (drain_done),
    .busy_vec_o      (busy_vec),
    .inflight_o      (inflight),
    .stall_cnt_o     (stall_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int pend_count();
    int c = 0;
    for (int i = 0; i < 32; i++) if (pend[i]) c++;
    return c;
  endfunction

  function automatic bit model_issue();
    bit hz;
    hz = (uses_src1 && pend[instruction[19:15]]) || (uses_src2 && pend[instruction[14:10]]) ||
         (writes_dst && (pend[instruction[24:20]] || pend_count() == 4));
    return instr_valid && phase == 0 && !hz && !rst;
  endfunction

  always @(posedge clk) begin
    bit iss;
    int n_pre;
    iss   = model_issue();
    n_pre = pend_count();
    if (rst) begin
      for (int i = 0; i < 32; i++) pend[i] = 1'b0;
      phase = 0;
      m_stalls = 0;
    end else begin
      if (instr_valid && !iss && m_stalls < 65535) m_stalls++;
      if (phase == 0 && drain_req) phase = 1;
      else if (phase == 1 && n_pre == 0) phase = 2;
      else if (phase == 2) phase = 0;
      if (write_reg) pend[write_reg_dst] = 1'b0;
      if (iss && writes_dst) pend[instruction[24:20]] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] eb;
      bit ed;
      eb = '0;
      for (int i = 0; i < 32; i++) eb[i] = pend[i];
      ed = model_issue();
      chk("dec_enable", {31'b0, dec_enable}, {31'b0, ed});
      chk("stall", {31'b0, stall}, {31'b0, instr_valid & ~ed});
      chk("busy_vec", busy_vec, eb);
      chk("inflight", {28'b0, inflight}, 32'(pend_count()));
      chk("stall_cnt", {16'b0, stall_cnt}, 32'(m_stalls));
      chk("drain_done", {31'b0, drain_done}, {31'b0, phase == 2});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    instr_valid = 0; instruction = '0; uses_src1 = 0; uses_src2 = 0; writes_dst = 0;
    write_reg = 0; write_reg_dst = '0; drain_req = 0;
  endtask

  task automatic put(input bit wr, input int d, input bit u1, input int s1, input bit u2, input int s2);
    instr_valid = 1;
    writes_dst  = wr;
    uses_src1   = u1;
    uses_src2   = u2;
    instruction = {7'b0, 5'(d), 5'(s1), 5'(s2), 10'b0};
  endtask

  task automatic wb(input int r);
    write_reg = 1; write_reg_dst = 5'(r);
  endtask

  initial begin
    idle();
    rst = 1;
    step(); step();
    chk_en = 1;
    rst = 0;
    settle();
    chk("reset busy_vec", busy_vec, 32'h0);
    chk("reset inflight", {28'b0, inflight}, 32'd0);
    chk("reset stall_cnt", {16'b0, stall_cnt}, 32'd0);
    chk("reset drain_done", {31'b0, drain_done}, 32'd0);

    // RAW on r5 held until the cycle after its writeback
    put(1, 5, 0, 0, 0, 0); settle(); chk("raw writer issues", {31'b0, dec_enable}, 32'd1); step();
    put(0, 0, 1, 5, 0, 0); settle(); chk("raw reader stalls", {31'b0, stall}, 32'd1); step();
    step();
    wb(5); settle(); chk("raw stall in wb cycle", {31'b0, dec_enable}, 32'd0); step();
    write_reg = 0; settle(); chk("raw reader issues", {31'b0, dec_enable}, 32'd1); step();
    idle(); settle();
    chk("raw stall_cnt", {16'b0, stall_cnt}, 32'd3);

    // same-cycle writeback of r7 does not unblock src2 reader
    put(1, 7, 0, 0, 0, 0); step();
    put(0, 0, 0, 0, 1, 7); wb(7); settle(); chk("src2 wb same cycle", {31'b0, stall}, 32'd1); step();
    write_reg = 0; settle(); chk("src2 issue next", {31'b0, dec_enable}, 32'd1); step();

    // in-flight limit
    for (int r = 1; r <= 4; r++) begin
      put(1, r, 0, 0, 0, 0); settle(); chk("fill issue", {31'b0, dec_enable}, 32'd1); step();
    end
    put(1, 9, 0, 0, 0, 0); settle();
    chk("full stall", {31'b0, stall}, 32'd1);
    chk("full inflight", {28'b0, inflight}, 32'd4);
    step(); step();
    wb(2); step();
    write_reg = 0; settle();
    chk("after wb inflight", {28'b0, inflight}, 32'd3);
    chk("fifth issues", {31'b0, dec_enable}, 32'd1);
    step();
    idle(); settle();
    chk("busy after fill", busy_vec, 32'h0000_021A);
    chk("stall_cnt after fill", {16'b0, stall_cnt}, 32'd7);

    // writer to busy r3 while r3 writes back
    put(1, 3, 0, 0, 0, 0); wb(3); settle(); chk("waw stall", {31'b0, stall}, 32'd1); step();
    write_reg = 0; settle(); chk("waw issue next", {31'b0, dec_enable}, 32'd1); step();
    idle(); settle();
    chk("waw busy3", {31'b0, busy_vec[3]}, 32'd1);
    chk("waw inflight", {28'b0, inflight}, 32'd4);
    wb(1); step(); wb(3); step(); wb(4); step(); wb(9); step();
    wb(20); step();
    idle(); settle();
    chk("drained by wb", {28'b0, inflight}, 32'd0);

    // r0 ordinary, then drain with two pending writes
    put(1, 0, 0, 0, 0, 0); step();
    put(0, 0, 1, 0, 0, 0); settle(); chk("r0 hazard", {31'b0, stall}, 32'd1); step();
    put(1, 10, 0, 0, 0, 0); step();
    put(0, 0, 1, 15, 0, 0); drain_req = 1; settle(); chk("issue in req cycle", {31'b0, dec_enable}, 32'd1); step();
    drain_req = 0; wb(0); settle(); chk("drain blocks", {31'b0, dec_enable}, 32'd0); step();
    wb(10); step();
    write_reg = 0; settle(); chk("drain empty no done yet", {31'b0, drain_done}, 32'd0); step();
    drain_req = 1; settle(); chk("drain_done pulse", {31'b0, drain_done}, 32'd1); step();
    drain_req = 0; settle();
    chk("drain_done single", {31'b0, drain_done}, 32'd0);
    chk("run resumes", {31'b0, dec_enable}, 32'd1);
    step();

    // drain with nothing pending
    idle(); drain_req = 1; step();
    drain_req = 0; settle(); chk("empty drain cycle1", {31'b0, drain_done}, 32'd0); step();
    settle(); chk("empty drain done", {31'b0, drain_done}, 32'd1); step();
    settle(); chk("empty drain over", {31'b0, drain_done}, 32'd0); step();

    // reset mid-operation
    put(1, 2, 0, 0, 0, 0); step();
    put(1, 5, 0, 0, 0, 0); step();
    idle(); settle();
    chk("pre-rst busy", busy_vec, 32'h0000_0024);
    chk("pre-rst inflight", {28'b0, inflight}, 32'd2);
    rst = 1; wb(2); put(1, 8, 0, 0, 0, 0); settle();
    chk("dec low in rst", {31'b0, dec_enable}, 32'd0);
    step();
    rst = 0; settle();
    chk("post-rst busy", busy_vec, 32'h0);
    chk("post-rst inflight", {28'b0, inflight}, 32'd0);
    chk("post-rst stall_cnt", {16'b0, stall_cnt}, 32'd0);
    chk("post-rst run", {31'b0, dec_enable}, 32'd1);
    step();

    // stall counter saturation
    put(0, 0, 1, 8, 0, 0);
    repeat (65540) step();
    settle();
    chk("stall_cnt saturates", {16'b0, stall_cnt}, 32'h0000_FFFF);
    idle(); step(); step();

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 MAX_INFLIGHT, 4, max register-writing instructions between issue and writeback (range 1..15).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 instr_valid  in  1  fetch presents an instruction to decode.
REQ-005 instruction  in  32  [24:20] dst, [19:15] src1, [14:10] src2.
REQ-006 uses_src1 / uses_src2 / writes_dst  in  1 each  operand-usage flags for the presented instruction.
REQ-007 WriteReg  in  1  writeback write strobe (same strobe the register file uses).
REQ-008 WriteRegdst  in  5  writeback destination register.
REQ-009 drain_req  in  1  pulse; request pipeline drain.
REQ-010 dec_enable  out  1  drives the decode-stage enable; high = instruction issues this cycle.
REQ-011 stall  out  1  instr_valid high and not issuing.
REQ-012 drain_done  out  1  one-cycle pulse when drain completes.
REQ-013 busy_vec  out  32  per-register pending-write bits.
REQ-014 inflight  out  4  count of pending writes.
REQ-015 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-016 States: RUN, DRAIN, DONE; reset state RUN.
REQ-017 Hazard = (uses_src1 & busy[src1]) | (uses_src2 & busy[src2]) | (writes_dst & busy[dst]) | (writes_dst & inflight==MAX_INFLIGHT).
REQ-018 dec_enable = instr_valid & state==RUN & ~hazard & ~rst, combinational, zero latency.
REQ-019 stall = instr_valid & ~dec_enable.
REQ-020 Hazard uses the pre-edge busy_vec: a writeback clearing register R in cycle N does not unblock a reader of R until cycle N+1 (register file write and decode read share the edge).
REQ-021 On edge with dec_enable & writes_dst: busy[dst] set.
REQ-022 On edge with WriteReg & busy[WriteRegdst]: that bit cleared; WriteReg to a non-busy register ignored.
REQ-023 Set and clear of the same register on one edge: bit ends set.
REQ-024 inflight +1 on set, -1 on effective clear, unchanged when both occur; never exceeds MAX_INFLIGHT nor wraps below 0.
REQ-025 Register 0 is an ordinary register (no hardwired zero).
REQ-026 RUN -> DRAIN on drain_req; DRAIN holds dec_enable low; DRAIN -> DONE when inflight==0; DONE asserts drain_done one cycle -> RUN.
REQ-027 drain_req with inflight already 0: RUN -> DRAIN -> DONE -> RUN (drain_done two cycles after request); drain_req in DRAIN/DONE ignored.
REQ-028 stall_cnt +1 per cycle stall is high, saturates at 0xFFFF.

Reset
REQ-029 rst synchronous: busy_vec=0, inflight=0, stall_cnt=0, state=RUN, drain_done=0; dec_enable low while rst high.
REQ-030 rst mid-operation discards all pending-write tracking; WriteReg in the rst cycle has no effect.

Structure
REQ-031 Shared package holds field-position constants (DST/SRC1/SRC2 MSB/LSB), state encoding, MAX_INFLIGHT default.
REQ-032 One sub-module natural: scoreboard_bits (32-bit busy vector with set/clear ports and 3 lookup ports); FSM and counters in the top.

Verification
REQ-033 Issue writes_dst dst=5, next cycle reader src1=5 -> stall=1, dec_enable=0 until cycle after WriteReg dst=5.
REQ-034 WriteReg dst=7 and reader src2=7 same cycle -> stall that cycle, issue next cycle.
REQ-035 MAX_INFLIGHT=4: issue dst 1,2,3,4 back-to-back, fifth writer dst=9 -> stall until any writeback; inflight reads 4 then 3.
REQ-036 Same-edge issue dst=3 and WriteReg dst=3 (busy) -> busy[3]=1, inflight unchanged.
REQ-037 inflight=2, drain_req -> dec_enable low; after both writebacks drain_done pulses once, RUN resumes.
REQ-038 rst asserted with busy_vec=0x0000_0024, inflight=2 -> next cycle busy_vec=0, inflight=0, stall_cnt=0, state RUN.
